// File: rtl/tpi_pkg.sv
// tpi_pkg: register addresses, port-0 mode encoding, STAT bits and handshake states
package tpi_pkg;
  localparam logic [3:0] ADDR_CTRL = 4'hC;
  localparam logic [3:0] ADDR_STAT = 4'hD;
  localparam logic [3:0] ADDR_IEN  = 4'hE;
  localparam int STAT_ILATCH = 0;
  localparam int STAT_ODONE  = 1;
  typedef enum logic [1:0] {
    MODE_PLAIN  = 2'd0,
    MODE_ILATCH = 2'd1,
    MODE_HS     = 2'd2,
    MODE_PULSE  = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_WAIT  = 2'd1,
    HS_PULSE = 2'd2
  } hs_state_e;
endpackage

// File: rtl/tpi_port.sv
// tpi_port: one GPIO port with PR, DDR, pin synchroniser, input latch and readback mux
module tpi_port #(
  parameter int PORT_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              we_pr_i,
  input  logic              we_ddr_i,
  input  logic              cap_i,
  input  logic              ilr_sel_i,
  input  logic [PORT_W-1:0] wdata_i,
  input  logic [PORT_W-1:0] pin_in_i,
  output logic [PORT_W-1:0] pin_out_o,
  output logic [PORT_W-1:0] pin_oe_o,
  output logic [PORT_W-1:0] rd_val_o
);
  logic [PORT_W-1:0] pr_q, ddr_q, ilr_q, pin_s;
  logic [SYNC_STAGES-1:0][PORT_W-1:0] sync_q;
  assign pin_s     = sync_q[SYNC_STAGES-1];
  assign pin_out_o = pr_q;
  assign pin_oe_o  = ddr_q;
  // driven bits read back the register, undriven bits read the pad
  assign rd_val_o  = ilr_sel_i ? ilr_q : (pr_q & ddr_q) | (pin_s & ~ddr_q);
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      pr_q   <= '0;
      ddr_q  <= '0;
      ilr_q  <= '0;
      sync_q <= '0;
    end else begin
      if (we_pr_i) pr_q <= wdata_i;
      if (we_ddr_i) ddr_q <= wdata_i;
      if (cap_i) ilr_q <= pin_s;
      sync_q <= (SYNC_STAGES*PORT_W)'({sync_q, pin_in_i});
    end
endmodule

// File: rtl/tpi_ports_hs.sv
// tpi_ports_hs: NPORTS GPIO ports behind a small register map, with port-0
// strobe latch / ready-ack / pulse handshakes and a maskable interrupt
module tpi_ports_hs #(
  parameter int NPORTS      = 3,
  parameter int PORT_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     cs_i,
  input  logic                     we_i,
  input  logic [3:0]               addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     rvalid_o,
  input  logic [NPORTS*PORT_W-1:0] pin_in_i,
  output logic [NPORTS*PORT_W-1:0] pin_out_o,
  output logic [NPORTS*PORT_W-1:0] pin_oe_o,
  input  logic                     stb_in_i,
  input  logic                     ack_in_i,
  output logic                     rdy_out_o,
  output logic                     irq_o
);
  import tpi_pkg::*;
  localparam int CW = PULSE_LEN > 1 ? $clog2(PULSE_LEN) : 1;
  logic wr, rd, we_pr0, wr_ctrl, wr_stat, wr_ien, mode_chg, cap, clr_rd, set_done;
  logic stb_edge, ack_edge, stb_hist_q, ack_hist_q;
  logic [SYNC_STAGES-1:0] stb_sync_q, ack_sync_q;
  logic [2:0] ctrl_q;
  logic [1:0] stat_q, stat_d, ien_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] rd_mux, rdata_q;
  logic rvalid_q;
  logic [NPORTS-1:0][PORT_W-1:0] rd_val;
  mode_e mode;
  hs_state_e st_q, st_d;
  assign mode     = mode_e'(ctrl_q[1:0]);
  assign wr       = cs_i & we_i;
  assign rd       = cs_i & ~we_i;
  assign we_pr0   = wr && addr_i == 4'd0;
  assign wr_ctrl  = wr && addr_i == ADDR_CTRL;
  assign wr_stat  = wr && addr_i == ADDR_STAT;
  assign wr_ien   = wr && addr_i == ADDR_IEN;
  assign mode_chg = wr_ctrl && wdata_i[1:0] != ctrl_q[1:0];
  // edge history runs in every mode so a mode switch never sees a stale edge
  assign stb_edge = ctrl_q[2] ? stb_sync_q[SYNC_STAGES-1] & ~stb_hist_q
                              : ~stb_sync_q[SYNC_STAGES-1] & stb_hist_q;
  assign ack_edge = ctrl_q[2] ? ack_sync_q[SYNC_STAGES-1] & ~ack_hist_q
                              : ~ack_sync_q[SYNC_STAGES-1] & ack_hist_q;
  assign cap      = mode == MODE_ILATCH && stb_edge;
  assign clr_rd   = rd && addr_i == 4'd0 && mode == MODE_ILATCH;
  assign stat_d   = (stat_q & ~((wr_stat ? wdata_i[1:0] : 2'b00) | {1'b0, clr_rd})) | {set_done, cap};
  assign rdy_out_o = st_q == HS_WAIT || (mode == MODE_PULSE && st_q != HS_PULSE);
  assign irq_o    = |(stat_q & ien_q);
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    tpi_port #(.PORT_W(PORT_W), .SYNC_STAGES(SYNC_STAGES)) u_port (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .we_pr_i  (wr && addr_i == 4'(g)),
      .we_ddr_i (wr && addr_i == 4'(NPORTS + g)),
      .cap_i    (g == 0 && cap),
      .ilr_sel_i(g == 0 && mode == MODE_ILATCH),
      .wdata_i  (wdata_i[PORT_W-1:0]),
      .pin_in_i (pin_in_i[g*PORT_W +: PORT_W]),
      .pin_out_o(pin_out_o[g*PORT_W +: PORT_W]),
      .pin_oe_o (pin_oe_o[g*PORT_W +: PORT_W]),
      .rd_val_o (rd_val[g])
    );
  end
  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < NPORTS; k++) begin
      if (addr_i == 4'(k)) rd_mux = 8'(rd_val[k]);
      if (addr_i == 4'(NPORTS + k)) rd_mux = 8'(pin_oe_o[k*PORT_W +: PORT_W]);
    end
    if (addr_i == ADDR_CTRL) rd_mux = {5'b0, ctrl_q};
    if (addr_i == ADDR_STAT) rd_mux = {6'b0, stat_q};
    if (addr_i == ADDR_IEN) rd_mux = {6'b0, ien_q};
  end
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    set_done = 1'b0;
    if (mode_chg) st_d = HS_IDLE;
    else if (mode == MODE_HS) begin
      if (st_q == HS_WAIT && ack_edge) begin
        st_d     = HS_IDLE;
        set_done = 1'b1;
      end
      if (we_pr0) st_d = HS_WAIT;
    end else if (mode == MODE_PULSE) begin
      if (we_pr0) begin
        st_d  = HS_PULSE;
        cnt_d = CW'(PULSE_LEN - 1);
      end else if (st_q == HS_PULSE) begin
        st_d     = cnt_q == '0 ? HS_IDLE : HS_PULSE;
        set_done = cnt_q == '0;
        cnt_d    = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
    end
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      ctrl_q     <= '0;
      stat_q     <= '0;
      ien_q      <= '0;
      st_q       <= HS_IDLE;
      cnt_q      <= '0;
      stb_sync_q <= '0;
      ack_sync_q <= '0;
      stb_hist_q <= 1'b0;
      ack_hist_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= wdata_i[2:0];
      if (wr_ien) ien_q <= wdata_i[1:0];
      stat_q     <= stat_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      stb_sync_q <= SYNC_STAGES'({stb_sync_q, stb_in_i});
      ack_sync_q <= SYNC_STAGES'({ack_sync_q, ack_in_i});
      stb_hist_q <= stb_sync_q[SYNC_STAGES-1];
      ack_hist_q <= ack_sync_q[SYNC_STAGES-1];
      rvalid_q   <= rd;
      if (rd) rdata_q <= rd_mux;
    end
endmodule

// File: tb/tb_tpi_ports_hs.sv
// tb_tpi_ports_hs: table vectors, handshake corner sequences and a randomised
// plain-port run against a behavioural register/pin model
module tb_tpi_ports_hs;
  localparam int NP = 3, PW = 8, SS = 2, PL = 4;
  logic clk = 1'b0, rst = 1'b1, cs = 1'b0, we = 1'b0, stb = 1'b0, ack = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0, rdata;
  logic rvalid, rdy, irq;
  logic [NP*PW-1:0] pin_in = '0, pin_out, pin_oe;
  int n_chk = 0, n_err = 0, low;
  typedef struct packed {logic w; logic [3:0] a; logic [7:0] d; logic [7:0] e;} vec_t;
  vec_t tbl[18];
  logic [7:0] m_pr[NP], m_ddr[NP], rexp, rw;
  logic [3:0] ra;
  logic [NP*PW-1:0] phist[$];
  int op;

  always #5 clk = ~clk;

  tpi_ports_hs #(.NPORTS(NP), .PORT_W(PW), .SYNC_STAGES(SS), .PULSE_LEN(PL)) dut (
    .clock_i(clk), .reset_i(rst), .cs_i(cs), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .rvalid_o(rvalid), .pin_in_i(pin_in), .pin_out_o(pin_out),
    .pin_oe_o(pin_oe), .stb_in_i(stb), .ack_in_i(ack), .rdy_out_o(rdy), .irq_o(irq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rdc(input string nm, input logic [3:0] a, input logic [7:0] e);
    cs = 1'b1; we = 1'b0; addr = a;
    tick;
    cs = 1'b0;
    chk({nm, "_rvalid"}, rvalid, 1);
    chk(nm, rdata, e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick;
  endtask

  // plain-port read value: driven bits from PR, others from pins seen two cycles earlier
  function automatic logic [7:0] exp_rd(input int a, input logic [NP*PW-1:0] pins);
    if (a < NP) return (m_pr[a] & m_ddr[a]) | (pins[a*PW +: PW] & ~m_ddr[a]);
    if (a < 2 * NP) return m_ddr[a-NP];
    return 8'h00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_rdata", rdata, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdy", rdy, 0);
    chk("reset_irq", irq, 0);
    chk("reset_pin_oe", pin_oe, 0);
    rst = 1'b0;
    tick;

    tbl[0]  = '{1'b1, 4'd3,  8'hFF, 8'h00};
    tbl[1]  = '{1'b1, 4'd0,  8'hC3, 8'h00};
    tbl[2]  = '{1'b0, 4'd0,  8'h00, 8'hC3};
    tbl[3]  = '{1'b0, 4'd3,  8'h00, 8'hFF};
    tbl[4]  = '{1'b1, 4'd5,  8'h0F, 8'h00};
    tbl[5]  = '{1'b1, 4'd2,  8'h5A, 8'h00};
    tbl[6]  = '{1'b0, 4'd2,  8'h00, 8'h9A};
    tbl[7]  = '{1'b1, 4'd6,  8'h77, 8'h00};
    tbl[8]  = '{1'b0, 4'd6,  8'h00, 8'h00};
    tbl[9]  = '{1'b0, 4'd15, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 4'd14, 8'hFF, 8'h00};
    tbl[11] = '{1'b0, 4'd14, 8'h00, 8'h03};
    tbl[12] = '{1'b1, 4'd12, 8'hFC, 8'h00};
    tbl[13] = '{1'b0, 4'd12, 8'h00, 8'h04};
    tbl[14] = '{1'b0, 4'd13, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 4'd12, 8'h00, 8'h00};
    tbl[16] = '{1'b1, 4'd14, 8'h00, 8'h00};
    tbl[17] = '{1'b0, 4'd5,  8'h00, 8'h0F};
    pin_in = 24'h960000;
    ticks(3);
    for (int i = 0; i < 18; i++)
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
      else rdc($sformatf("table_%0d", i), tbl[i].a, tbl[i].e);

    wr(4'd4, 8'hF0);
    wr(4'd1, 8'hA5);
    pin_in[15:8] = 8'h3C;
    ticks(3);
    cs = 1'b1; we = 1'b0; addr = 4'd1;
    tick;
    cs = 1'b0;
    chk("dirmix_rvalid", rvalid, 1);
    chk("dirmix_rdata", rdata, 8'hAC);
    chk("dirmix_pin_out", pin_out[15:8], 8'hA5);
    chk("dirmix_pin_oe", pin_oe[15:8], 8'hF0);
    tick;
    chk("rvalid_drop", rvalid, 0);
    chk("rdata_hold", rdata, 8'hAC);

    do_reset;
    pin_in[7:0] = 8'h5A;
    wr(4'hC, 8'h05);
    wr(4'hE, 8'h01);
    stb = 1'b1;
    ticks(2);
    chk("ilatch_early_irq", irq, 0);
    tick;
    chk("ilatch_irq", irq, 1);
    chk("ilatch_rdy", rdy, 0);
    rdc("ilatch_stat", 4'hD, 8'h01);
    pin_in[7:0] = 8'hFF;
    ticks(3);
    rdc("ilatch_pr0", 4'h0, 8'h5A);
    chk("ilatch_irq_clr", irq, 0);
    rdc("ilatch_stat_clr", 4'hD, 8'h00);

    stb = 1'b0;
    pin_in[7:0] = 8'h11;
    ticks(4);
    chk("falling_stb_ignored", irq, 0);
    stb = 1'b1;
    ticks(2);
    wr(4'hD, 8'h01);
    chk("coll_irq", irq, 1);
    rdc("coll_stat", 4'hD, 8'h01);
    rdc("coll_ilr", 4'h0, 8'h11);

    do_reset;
    wr(4'hC, 8'h02);
    wr(4'hE, 8'h02);
    ack = 1'b1;
    ticks(4);
    chk("hs_idle_rdy", rdy, 0);
    wr(4'h0, 8'h33);
    chk("hs_rdy_set", rdy, 1);
    chk("hs_pin_out", pin_out[7:0], 8'h33);
    ack = 1'b0;
    ticks(2);
    chk("hs_rdy_hold", rdy, 1);
    tick;
    chk("hs_rdy_clr", rdy, 0);
    chk("hs_irq", irq, 1);
    rdc("hs_stat", 4'hD, 8'h02);
    ack = 1'b1;
    ticks(3);
    ack = 1'b0;
    ticks(4);
    chk("hs_2nd_ack_rdy", rdy, 0);
    rdc("hs_2nd_ack_stat", 4'hD, 8'h02);
    wr(4'hD, 8'h02);
    chk("hs_w1c_irq", irq, 0);
    ack = 1'b1;
    ticks(3);
    wr(4'h0, 8'h44);
    ack = 1'b0;
    ticks(2);
    wr(4'h0, 8'h55);
    chk("hs_coll_rdy", rdy, 1);
    chk("hs_coll_irq", irq, 1);

    wr(4'hC, 8'h03);
    chk("pulse_idle_rdy", rdy, 1);
    wr(4'hD, 8'h03);
    chk("pulse_stat_clr", irq, 0);
    low = 0;
    wr(4'h0, 8'h01);
    if (!rdy) low++;
    tick;
    if (!rdy) low++;
    wr(4'h0, 8'h02);
    if (!rdy) low++;
    for (int i = 0; i < 10 && !rdy; i++) begin
      if (low == 6) chk("pulse_irq_before_end", irq, 0);
      tick;
      if (!rdy) low++;
    end
    chk("pulse_low_cycles", low, 6);
    chk("pulse_rdy_end", rdy, 1);
    chk("pulse_irq", irq, 1);

    pin_in = '0;
    stb = 1'b0;
    wr(4'hC, 8'h02);
    wr(4'h3, 8'hFF);
    wr(4'hE, 8'h03);
    wr(4'h0, 8'h77);
    rdc("pre_reset_pr0", 4'h0, 8'h77);
    chk("pre_reset_rdy", rdy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_rdy", rdy, 0);
    chk("async_reset_pin_oe", pin_oe, 0);
    chk("async_reset_pin_out", pin_out, 0);
    chk("async_reset_irq", irq, 0);
    chk("async_reset_rdata", rdata, 0);
    tick;
    rst = 1'b0;
    ticks(3);
    for (int a = 0; a < 15; a++) rdc($sformatf("post_reset_reg%0d", a), 4'(a), 8'h00);

    do_reset;
    for (int i = 0; i < NP; i++) begin
      m_pr[i] = '0;
      m_ddr[i] = '0;
    end
    ticks(3);
    phist.push_back('0);
    phist.push_back('0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) pin_in = 24'($urandom);
      phist.push_back(pin_in);
      op = $urandom_range(2);
      ra = 4'($urandom);
      rw = 8'($urandom);
      if (op == 1 && ra > 4'd11) ra = ra - 4'd4;
      cs = op != 0; we = op == 1; addr = ra; wdata = rw;
      rexp = exp_rd(int'(ra), phist[n]);
      tick;
      cs = 1'b0; we = 1'b0;
      if (op == 2) begin
        chk("rand_rdata", rdata, rexp);
        chk("rand_rvalid", rvalid, 1);
      end else chk("rand_rvalid0", rvalid, 0);
      if (op == 1 && ra < 4'(NP)) m_pr[ra] = rw;
      else if (op == 1 && ra < 4'(2 * NP)) m_ddr[ra-4'(NP)] = rw;
      chk("rand_pin_out", pin_out, {m_pr[2], m_pr[1], m_pr[0]});
      chk("rand_pin_oe", pin_oe, {m_ddr[2], m_ddr[1], m_ddr[0]});
      chk("rand_rdy_irq", {rdy, irq}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
